// File: rtl/fsm_edge_detect_multi.sv
// Multi-channel edge detector: per-channel INIT/LOW/HIGH FSM, Mealy edge pulse, sticky flag, saturating count.
// Optional FSM_EDGE_SYNC_EN: two-flop input synchroniser per channel (adds 2 cycles of edge latency).
module fsm_edge_detect_multi #(
    parameter int CH    = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH-1:0]         din,
    input  logic [2*CH-1:0]       mode,
    input  logic [CH-1:0]         clr,
    output logic [CH-1:0]         dout,
    output logic [CH-1:0]         evt,
    output logic [CH*CNT_W-1:0]   cnt,
    output logic                  any_evt
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [CH-1:0] s_s;

`ifdef FSM_EDGE_SYNC_EN
    logic [CH-1:0] sync1_r;
    logic [CH-1:0] sync2_r;

    // Two-flop synchroniser for all channel inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= {CH{1'b0}};
            sync2_r <= {CH{1'b0}};
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
        end
    end

    assign s_s = sync2_r;
`else
    assign s_s = din;
`endif

    genvar g;
    for (g = 0; g < CH; g++) begin : g_ch
        state_t           state_r;
        logic             rise_s;
        logic             fall_s;
        logic             dout_s;
        logic             evt_r;
        logic [CNT_W-1:0] cnt_r;

        // Edge decode from current level state and sampled input
        always_comb begin
            rise_s = 1'b0;
            fall_s = 1'b0;
            case (state_r)
                ST_LOW:  rise_s = s_s[g];
                ST_HIGH: fall_s = ~s_s[g];
                default: begin
                    rise_s = 1'b0;
                    fall_s = 1'b0;
                end
            endcase
        end

        assign dout_s = (rise_s & mode[2*g]) | (fall_s & mode[2*g+1]);

        // Level-tracking FSM with sticky flag and saturating counter
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_r <= ST_INIT;
                evt_r   <= 1'b0;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                case (state_r)
                    ST_INIT: state_r <= s_s[g] ? ST_HIGH : ST_LOW;
                    ST_LOW:  state_r <= s_s[g] ? ST_HIGH : ST_LOW;
                    ST_HIGH: state_r <= s_s[g] ? ST_HIGH : ST_LOW;
                    default: state_r <= ST_INIT;
                endcase
                // A pulse in the same cycle as clear wins: flag stays set, count restarts at one
                if (dout_s) begin
                    evt_r <= 1'b1;
                    cnt_r <= clr[g] ? CNT_ONE : sat_inc(cnt_r);
                end else if (clr[g]) begin
                    evt_r <= 1'b0;
                    cnt_r <= {CNT_W{1'b0}};
                end else begin
                    evt_r <= evt_r;
                    cnt_r <= cnt_r;
                end
            end
        end

        assign dout[g]                 = dout_s;
        assign evt[g]                  = evt_r;
        assign cnt[g*CNT_W +: CNT_W]   = cnt_r;
    end

    assign any_evt = |evt;

endmodule

// File: tb/tb_fsm_edge_detect_multi.sv
// Bench for fsm_edge_detect_multi: directed scenarios plus random stimulus against a level-change model.
module tb_fsm_edge_detect_multi;

    localparam int CH    = 4;
    localparam int CNT_W = 4;
    localparam int MAXC  = 15;
`ifdef FSM_EDGE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [CH-1:0]       din;
    logic [2*CH-1:0]     mode;
    logic [CH-1:0]       clr;
    logic [CH-1:0]       dout;
    logic [CH-1:0]       evt;
    logic [CH*CNT_W-1:0] cnt;
    logic                any_evt;

    int n_checks = 0;
    int n_fail   = 0;
    int pc [CH]  = '{default: 0};

    // Model state: last seen level per channel, whether a level has been seen, flag, count, sync pipe
    bit m_valid [CH];
    bit m_prev  [CH];
    bit m_evt   [CH];
    int m_cnt   [CH];
    bit p1      [CH];
    bit p2      [CH];

    always #5 clk = ~clk;

    fsm_edge_detect_multi #(.CH(CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .clr(clr),
        .dout(dout), .evt(evt), .cnt(cnt), .any_evt(any_evt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit s_of(int i);
        if (LAT == 0) return din[i];
        return p2[i];
    endfunction

    function automatic bit exp_pulse(int i);
        bit s;
        s = s_of(i);
        if (!m_valid[i] || s == m_prev[i]) return 1'b0;
        return s ? mode[2*i] : mode[2*i+1];
    endfunction

    function automatic logic [CH-1:0] exp_dout();
        for (int i = 0; i < CH; i++) exp_dout[i] = exp_pulse(i);
    endfunction

    function automatic logic [CH-1:0] exp_evt();
        for (int i = 0; i < CH; i++) exp_evt[i] = m_evt[i];
    endfunction

    function automatic logic [CH*CNT_W-1:0] exp_cnt();
        for (int i = 0; i < CH; i++) exp_cnt[i*CNT_W +: CNT_W] = m_cnt[i][CNT_W-1:0];
    endfunction

    function automatic int cnt_of(int i);
        return int'(cnt[i*CNT_W +: CNT_W]);
    endfunction

    // Reference model update
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                m_valid[i] <= 1'b0; m_prev[i] <= 1'b0; m_evt[i] <= 1'b0;
                m_cnt[i] <= 0; p1[i] <= 1'b0; p2[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (exp_pulse(i)) begin
                    m_evt[i] <= 1'b1;
                    m_cnt[i] <= clr[i] ? 1 : ((m_cnt[i] >= MAXC) ? MAXC : m_cnt[i] + 1);
                end else if (clr[i]) begin
                    m_evt[i] <= 1'b0;
                    m_cnt[i] <= 0;
                end
                m_prev[i]  <= s_of(i);
                m_valid[i] <= 1'b1;
                p2[i]      <= p1[i];
                p1[i]      <= din[i];
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("dout", 32'(dout), 32'(exp_dout()));
        check("evt", 32'(evt), 32'(exp_evt()));
        check("cnt", 32'(cnt), 32'(exp_cnt()));
        check("any_evt", 32'(any_evt), 32'(|exp_evt()));
    end

    // Pulse counters for directed expectations
    always @(negedge clk) begin
        for (int i = 0; i < CH; i++) if (rst && dout[i]) pc[i] <= pc[i] + 1;
    end

    initial begin
        int b;
        din  = 4'b1111;
        mode = 8'hFF;
        clr  = 4'b0000;
        rst  = 1'b0;
        repeat (3) tick();
        check("reset_evt", 32'(evt), 32'd0);
        check("reset_cnt", 32'(cnt), 32'd0);
        check("reset_any", 32'(any_evt), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);

        rst = 1'b1;
        b = pc[0] + pc[1] + pc[2] + pc[3];
        repeat (5) tick();
`ifndef FSM_EDGE_SYNC_EN
        check("release_pulses", 32'(pc[0] + pc[1] + pc[2] + pc[3] - b), 32'd0);
        check("release_evt", 32'(evt), 32'd0);
        check("release_cnt", 32'(cnt), 32'd0);
`endif
        clr = 4'b1111; tick(); clr = 4'b0000;
        mode = 8'b00_01_11_01;

        // ch0 rise-only
        b = pc[0];
        din[0] = 1'b0; repeat (LAT + 2) tick();
        din[0] = 1'b1; repeat (2) tick();
        din[0] = 1'b0; repeat (LAT + 2) tick();
        check("ch0_pulses", 32'(pc[0] - b), 32'd1);
        check("ch0_evt", 32'(evt[0]), 32'd1);
        check("ch0_cnt", 32'(cnt_of(0)), 32'd1);

        // ch1 both edges, saturation
        b = pc[1];
        repeat (20) begin din[1] = ~din[1]; tick(); end
        repeat (LAT + 2) tick();
        check("ch1_pulses", 32'(pc[1] - b), 32'd20);
        check("ch1_cnt_sat", 32'(cnt_of(1)), 32'd15);
        check("ch1_evt", 32'(evt[1]), 32'd1);
        check("ch1_any", 32'(any_evt), 32'd1);

        // ch2 clear vs edge collision
        repeat (5) begin din[2] = 1'b0; tick(); din[2] = 1'b1; tick(); end
        repeat (LAT + 2) tick();
        check("ch2_cnt5", 32'(cnt_of(2)), 32'd5);
        din[2] = 1'b0; repeat (LAT + 2) tick();
        din[2] = 1'b1; repeat (LAT) tick();
        clr[2] = 1'b1; tick(); clr[2] = 1'b0;
        check("ch2_clr_edge_evt", 32'(evt[2]), 32'd1);
        check("ch2_clr_edge_cnt", 32'(cnt_of(2)), 32'd1);
        clr = 4'b0111; tick(); clr = 4'b0000;
        check("clr_evt", 32'(evt), 32'd0);
        check("clr_any", 32'(any_evt), 32'd0);
        check("clr_cnt2", 32'(cnt_of(2)), 32'd0);

        // ch3 reset mid-count
        mode = 8'b01_01_11_01;
        repeat (7) begin din[3] = 1'b0; tick(); din[3] = 1'b1; tick(); end
        repeat (LAT + 2) tick();
        check("ch3_cnt7", 32'(cnt_of(3)), 32'd7);
        din[3] = 1'b0; tick();
        din[3] = 1'b1; #2;
        rst = 1'b0; #1;
        check("midrst_cnt3", 32'(cnt_of(3)), 32'd0);
        check("midrst_evt", 32'(evt), 32'd0);
        check("midrst_any", 32'(any_evt), 32'd0);
        check("midrst_dout", 32'(dout), 32'd0);
        tick(); tick();
        rst = 1'b1;
        b = pc[3];
        repeat (LAT + 4) tick();
`ifndef FSM_EDGE_SYNC_EN
        check("release_ch3_pulses", 32'(pc[3] - b), 32'd0);
`else
        din[0] = 1'b0; repeat (4) tick();
        b = pc[0];
        din[0] = 1'b1; tick();
        check("sync_lat1", 32'(dout[0]), 32'd0);
        tick();
        check("sync_lat2", 32'(dout[0]), 32'd1);
        tick();
        check("sync_lat3", 32'(dout[0]), 32'd0);
`endif

        // Random phase
        repeat (3000) begin
            din  = CH'($urandom);
            mode = (2*CH)'($urandom);
            clr  = ($urandom_range(0, 39) == 0) ? CH'($urandom) : 4'b0000;
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b0; tick(); rst = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
